// File: rtl/dbus_arbiter.sv
// -----------------------------------------------------------------------------
// dbus_pkg + dbus_arbiter
//
// Purpose:
//   Shares one downstream data-bus port among NREQ requesters:
//   index 0 = fetch MMU walker, 1 = memory MMU walker, 2 = load/store unit.
//   One requester is granted at a time. Its request is registered and held
//   stable on dreq until data_ok. The response is routed back to the owner only.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-low reset
//   ureq   in   NREQ upstream requests (dbus_req_t)
//   uresp  out  NREQ upstream responses (dbus_resp_t), zero for non-owners
//   dreq   out  registered downstream request
//   dresp  in   downstream response
//   grant  out  index of current owner, meaningful while busy=1
//   busy   out  a downstream transaction is outstanding
// -----------------------------------------------------------------------------
package dbus_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int NREQ       = 3,
    parameter bit FIXED_PRIO = 1'b0,
    localparam int GW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  dbus_req_t  [NREQ-1:0]      ureq,
    output dbus_resp_t [NREQ-1:0]      uresp,
    output dbus_req_t                  dreq,
    input  dbus_resp_t                 dresp,
    output logic       [GW-1:0]        grant,
    output logic                       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   ptr_q,   ptr_d;
    dbus_req_t       req_q,   req_d;

    logic [GW-1:0]   winner;
    logic            any_valid;
    int              scan_idx;
    logic [GW-1:0]   scan_sel;

    // Winner selection. Round-robin scans upward from the pointer with
    // wrap-around; fixed priority always scans from index 0. The first
    // asserted valid found along the scan wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        scan_idx  = 0;
        scan_sel  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = FIXED_PRIO ? k : (int'(ptr_q) + k);
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            scan_sel = GW'(scan_idx);
            if (!any_valid && ureq[scan_sel].valid) begin
                any_valid = 1'b1;
                winner    = scan_sel;
            end
        end
    end

    // Next-state logic. The payload is copied only on the IDLE->BUSY edge,
    // so dreq never has a combinational path from ureq.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        req_d   = req_q;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d     = BUSY;
                    grant_d     = winner;
                    req_d       = ureq[winner];
                    req_d.valid = 1'b0;   // valid is derived from state instead
                end
            end
            BUSY: begin
                // The data_ok cycle is the last BUSY cycle. The owner may already
                // have dropped valid. The transaction still runs to completion.
                if (dresp.data_ok) begin
                    state_d = IDLE;
                    req_d   = '0;
                    if (!FIXED_PRIO) begin
                        ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : (grant_q + GW'(1));
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            req_q   <= req_d;
        end
    end

    assign busy  = (state_q == BUSY);
    assign grant = grant_q;

    always_comb begin
        dreq       = req_q;
        dreq.valid = busy;
    end

    // Response demux. Only the owner sees dresp, and only while BUSY. A
    // data_ok that arrives while IDLE therefore reaches nobody.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
        assign uresp[gi] = (busy && (grant_q == GW'(gi))) ? dresp : '0;
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dbus_arbiter
//
// Directed bench for dbus_arbiter.
//   dut_rr uses round-robin arbitration (FIXED_PRIO=0).
//   dut_fp uses fixed priority (FIXED_PRIO=1).
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// 1 time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_dbus_arbiter;
    import dbus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    dbus_req_t  [2:0] ureq_a, ureq_b;
    dbus_resp_t [2:0] uresp_a, uresp_b;
    dbus_req_t        dreq_a, dreq_b;
    dbus_resp_t       dresp_a, dresp_b;
    logic [1:0]       grant_a, grant_b;
    logic             busy_a, busy_b;

    dbus_arbiter #(.NREQ(3), .FIXED_PRIO(1'b0)) dut_rr (
        .clk   (clk),
        .reset (rst_n),
        .ureq  (ureq_a),
        .uresp (uresp_a),
        .dreq  (dreq_a),
        .dresp (dresp_a),
        .grant (grant_a),
        .busy  (busy_a)
    );

    dbus_arbiter #(.NREQ(3), .FIXED_PRIO(1'b1)) dut_fp (
        .clk   (clk),
        .reset (rst_n),
        .ureq  (ureq_b),
        .uresp (uresp_b),
        .dreq  (dreq_b),
        .dresp (dresp_b),
        .grant (grant_b),
        .busy  (busy_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Requester i uses the distinct address 0x1000*(i+1).
    function automatic dbus_req_t mk_req(input logic [1:0] i);
        dbus_req_t r;
        r        = '0;
        r.valid  = 1'b1;
        r.addr   = 64'h1000 * (64'(i) + 64'd1);
        r.size   = MSIZE4;
        r.strobe = 8'h0F;
        r.data   = 64'hA0 + 64'(i);
        return r;
    endfunction

    logic [1:0] exp_order [4];

    initial begin
        ureq_a  = '0;
        ureq_b  = '0;
        dresp_a = '0;
        dresp_b = '0;
        rst_n   = 1'b0;

        // ---------------- reset state ----------------
        step();
        chk("rst_busy",      64'(busy_a),           64'd0);
        chk("rst_grant",     64'(grant_a),          64'd0);
        chk("rst_dreq_vld",  64'(dreq_a.valid),     64'd0);
        chk("rst_dreq_addr", dreq_a.addr,           64'd0);
        chk("rst_u0_dok",    64'(uresp_a[0].data_ok), 64'd0);
        chk("rst_u2_data",   uresp_a[2].data,       64'd0);
        rst_n = 1'b1;
        step();

        // ---------------- single request from LSU ----------------
        ureq_a[2]        = '0;
        ureq_a[2].valid  = 1'b1;
        ureq_a[2].addr   = 64'h8000_1000;
        ureq_a[2].size   = MSIZE8;
        ureq_a[2].strobe = 8'hFF;
        ureq_a[2].data   = 64'hDEAD_BEEF;
        #1;
        chk("single_idle_dvld", 64'(dreq_a.valid), 64'd0);
        step();
        dresp_a.addr_ok = 1'b1;
        #1;
        chk("single_b1_vld",   64'(dreq_a.valid),   64'd1);
        chk("single_b1_addr",  dreq_a.addr,         64'h8000_1000);
        chk("single_b1_grant", 64'(grant_a),        64'd2);
        chk("single_b1_aok2",  64'(uresp_a[2].addr_ok), 64'd1);
        chk("single_b1_aok0",  64'(uresp_a[0].addr_ok), 64'd0);
        step();
        dresp_a.addr_ok = 1'b0;
        #1;
        chk("single_b2_addr",  dreq_a.addr,         64'h8000_1000);
        chk("single_b2_dok2",  64'(uresp_a[2].data_ok), 64'd0);
        step();
        dresp_a.data_ok = 1'b1;
        dresp_a.data    = 64'h1234;
        #1;
        chk("single_b3_addr",  dreq_a.addr,         64'h8000_1000);
        chk("single_b3_strb",  64'(dreq_a.strobe),  64'hFF);
        chk("single_b3_wdata", dreq_a.data,         64'hDEAD_BEEF);
        chk("single_b3_dok2",  64'(uresp_a[2].data_ok), 64'd1);
        chk("single_b3_data2", uresp_a[2].data,     64'h1234);
        chk("single_b3_dok0",  64'(uresp_a[0].data_ok), 64'd0);
        chk("single_b3_dok1",  64'(uresp_a[1].data_ok), 64'd0);
        chk("single_b3_data1", uresp_a[1].data,     64'd0);
        step();
        ureq_a[2].valid = 1'b0;
        dresp_a         = '0;
        #1;
        chk("single_done_busy", 64'(busy_a),        64'd0);

        // ---------------- spurious data_ok while IDLE ----------------
        step();
        dresp_a.data_ok = 1'b1;
        dresp_a.data    = 64'hFFFF;
        #1;
        chk("spur_dok0", 64'(uresp_a[0].data_ok), 64'd0);
        chk("spur_dok1", 64'(uresp_a[1].data_ok), 64'd0);
        chk("spur_dok2", 64'(uresp_a[2].data_ok), 64'd0);
        step();
        dresp_a = '0;
        #1;
        chk("spur_busy", 64'(busy_a), 64'd0);

        // ---------------- three-way round-robin contention ----------------
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ureq_a[0] = mk_req(2'd0);
        ureq_a[1] = mk_req(2'd1);
        ureq_a[2] = mk_req(2'd2);
        exp_order[0] = 2'd0;
        exp_order[1] = 2'd1;
        exp_order[2] = 2'd2;
        exp_order[3] = 2'd0;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk($sformatf("rr%0d_idle_busy", n), 64'(busy_a), 64'd0);
            step();
            dresp_a.data_ok = 1'b1;
            dresp_a.data    = 64'h5500 + 64'(n);
            #1;
            chk($sformatf("rr%0d_grant", n), 64'(grant_a), 64'(exp_order[n]));
            chk($sformatf("rr%0d_addr", n),  dreq_a.addr,
                64'h1000 * (64'(exp_order[n]) + 64'd1));
            chk($sformatf("rr%0d_dok_own", n),
                64'(uresp_a[exp_order[n]].data_ok), 64'd1);
            step();
            dresp_a = '0;
        end
        ureq_a = '0;

        // ---------------- owner drops valid mid-transaction ----------------
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ureq_a[0] = mk_req(2'd0);
        ureq_a[1] = mk_req(2'd1);
        step();
        #1;
        chk("drop_grant", 64'(grant_a), 64'd0);
        step();
        ureq_a[0].valid = 1'b0;
        #1;
        chk("drop_dvld_held", 64'(dreq_a.valid), 64'd1);
        chk("drop_addr_held", dreq_a.addr,        64'h1000);
        step();
        dresp_a.data_ok = 1'b1;
        #1;
        chk("drop_dok0", 64'(uresp_a[0].data_ok), 64'd1);
        chk("drop_dok1", 64'(uresp_a[1].data_ok), 64'd0);
        step();
        dresp_a = '0;
        #1;
        chk("drop_idle_busy", 64'(busy_a), 64'd0);
        chk("drop_idle_dok0", 64'(uresp_a[0].data_ok), 64'd0);
        step();
        #1;
        chk("drop_next_grant", 64'(grant_a), 64'd1);
        dresp_a.data_ok = 1'b1;
        step();
        dresp_a = '0;
        ureq_a  = '0;

        // ---------------- reset in the middle of a transaction ----------------
        // The pointer is now 2, so requester 2 wins before the reset.
        // After the reset, requester 1 must win because the pointer is back at 0.
        ureq_a[1] = mk_req(2'd1);
        ureq_a[2] = mk_req(2'd2);
        step();
        #1;
        chk("mrst_pre_grant", 64'(grant_a), 64'd2);
        step();
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 64'(busy_a),       64'd0);
        chk("mrst_dvld", 64'(dreq_a.valid), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        #1;
        chk("mrst_post_grant", 64'(grant_a), 64'd1);
        chk("mrst_post_busy",  64'(busy_a),  64'd1);
        dresp_a.data_ok = 1'b1;
        step();
        dresp_a = '0;
        ureq_a  = '0;

        // ---------------- fixed priority ----------------
        ureq_b[1] = mk_req(2'd1);
        ureq_b[2] = mk_req(2'd2);
        for (int n = 0; n < 3; n++) begin
            ureq_b[0] = mk_req(2'd0);
            #1;
            chk($sformatf("fp%0d_idle_busy", n), 64'(busy_b), 64'd0);
            step();
            ureq_b[0].valid = 1'b0;
            dresp_b.data_ok = 1'b1;
            #1;
            chk($sformatf("fp%0d_grant", n), 64'(grant_b), 64'd0);
            chk($sformatf("fp%0d_dok0", n),  64'(uresp_b[0].data_ok), 64'd1);
            chk($sformatf("fp%0d_dok2", n),  64'(uresp_b[2].data_ok), 64'd0);
            step();
            dresp_b = '0;
        end
        step();
        #1;
        chk("fp_final_grant", 64'(grant_b), 64'd1);
        dresp_b.data_ok = 1'b1;
        step();
        dresp_b = '0;
        ureq_b  = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
